// File: rtl/snake_pkg.sv
// snake_pkg: playfield constants, spawner FSM states and Galois LFSR tap table
// rev 1.0
`default_nettype none

package snake_pkg;

  localparam int PF_X_W   = 7;
  localparam int PF_Y_W   = 6;
  localparam int PF_X_MIN = 5;
  localparam int PF_X_MAX = 67;
  localparam int PF_Y_MIN = 7;
  localparam int PF_Y_MAX = 53;
  localparam int PF_X_RST = 40;
  localparam int PF_Y_RST = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CHECK = 2'd2
  } spawn_state_t;

  // Right-shifting Galois feedback masks for maximal-length sequences; 0 = unsupported width.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_gen.sv
// lfsr_gen: free-running right-shift Galois LFSR, taps from the shared tap table
// rev 1.0
`default_nettype none

module lfsr_gen
  import snake_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  if (TAPS == '0 || SEED == '0) begin : g_bad_params
    $error("lfsr_gen: unsupported width or zero seed");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[W-1:1]} ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/apple_spawner.sv
// apple_spawner: draws LFSR-based candidates inside the playfield window and
// retries against the snake-body occupancy query until a free cell or budget end. rev 1.0
`default_nettype none

module apple_spawner
  import snake_pkg::*;
#(
  parameter int                X_W       = PF_X_W,
  parameter int                Y_W       = PF_Y_W,
  parameter int                X_MIN     = PF_X_MIN,
  parameter int                X_MAX     = PF_X_MAX,
  parameter int                Y_MIN     = PF_Y_MIN,
  parameter int                Y_MAX     = PF_Y_MAX,
  parameter int                X_RST     = PF_X_RST,
  parameter int                Y_RST     = PF_Y_RST,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                MAX_TRIES = 8
) (
  input  logic           clk_25M,
  input  logic           rst,
  input  logic           apple_gen,
  input  logic           occ_ack,
  input  logic           occ_hit,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  output logic [X_W-1:0] apple_x_pos,
  output logic [Y_W-1:0] apple_y_pos,
  output logic           apple_busy,
  output logic           apple_done,
  output logic           apple_fail
);

  localparam int SX  = X_MAX - X_MIN + 1;
  localparam int SY  = Y_MAX - Y_MIN + 1;
  localparam int WX  = $clog2(SX);
  localparam int WY  = $clog2(SY);
  localparam int WXP = WX + 1;
  localparam int WYP = WY + 1;
  localparam logic [WX:0] SX_V = WXP'(SX);
  localparam logic [WY:0] SY_V = WYP'(SY);

  if ((2 ** WX) > 2 * SX || (2 ** WY) > 2 * SY || WX + WY > LFSR_W ||
      X_MAX >= (2 ** X_W) || Y_MAX >= (2 ** Y_W)) begin : g_bad_window
    $error("apple_spawner: window does not fit the coordinate or LFSR widths");
  end

  if (X_RST < X_MIN || X_RST > X_MAX || Y_RST < Y_MIN || Y_RST > Y_MAX ||
      MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_config
    $error("apple_spawner: reset position outside window or illegal try budget");
  end

  logic [LFSR_W-1:0] lfsr;

  lfsr_gen #(
    .W    (LFSR_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk_25M),
    .rst   (rst),
    .state (lfsr)
  );

  if (WX + WY < LFSR_W) begin : g_unused_lfsr
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:WX+WY];
  end

  // One conditional subtract is enough because the raw field is below 2*span.
  logic [WX-1:0]  raw_x, fold_x;
  logic [WY-1:0]  raw_y, fold_y;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;

  always_comb begin
    raw_x  = lfsr[WX-1:0];
    raw_y  = lfsr[WX+WY-1:WX];
    fold_x = ({1'b0, raw_x} >= SX_V) ? WX'({1'b0, raw_x} - SX_V) : raw_x;
    fold_y = ({1'b0, raw_y} >= SY_V) ? WY'({1'b0, raw_y} - SY_V) : raw_y;
    cand_x = X_W'(X_MIN) + X_W'(fold_x);
    cand_y = Y_W'(Y_MIN) + Y_W'(fold_y);
  end

  spawn_state_t state, state_nxt;
  logic [7:0]   tries;
  logic         last_try;

  assign last_try = (tries == 8'(MAX_TRIES));

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (apple_gen) state_nxt = DRAW;
      DRAW:    state_nxt = CHECK;
      CHECK: begin
        if (occ_ack) begin
          state_nxt = (occ_hit && !last_try) ? DRAW : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      tries       <= '0;
      occ_req     <= 1'b0;
      occ_x       <= '0;
      occ_y       <= '0;
      apple_x_pos <= X_W'(X_RST);
      apple_y_pos <= Y_W'(Y_RST);
      apple_busy  <= 1'b0;
      apple_done  <= 1'b0;
      apple_fail  <= 1'b0;
    end else begin
      apple_done <= 1'b0;
      apple_fail <= 1'b0;
      apple_busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (apple_gen) tries <= '0;
        end
        DRAW: begin
          occ_x   <= cand_x;
          occ_y   <= cand_y;
          tries   <= tries + 8'd1;
          occ_req <= 1'b1;
        end
        CHECK: begin
          if (occ_ack) begin
            occ_req <= 1'b0;
            // Budget exhausted: the last candidate is committed anyway and flagged.
            if (!occ_hit || last_try) begin
              apple_x_pos <= occ_x;
              apple_y_pos <= occ_y;
              apple_done  <= 1'b1;
              apple_fail  <= occ_hit;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/apple_spawner.md
# apple_spawner

Parametrised apple placement engine for the snake game. On a spawn request it draws pseudo-random grid coordinates from a free-running LFSR, folds them into a configurable playfield window, and checks each candidate against the snake body through an occupancy query handshake, retrying until a free cell is found or a retry budget is exhausted. It sits between the game-control FSM, which issues `apple_gen`, and the snake body store, which answers occupancy queries; its position outputs feed the VGA renderer and the collision logic.

## Interface
- `X_W`, 7: x coordinate width.
- `Y_W`, 6: y coordinate width.
- `X_MIN` / `X_MAX`, 5 / 67: inclusive x window.
- `Y_MIN` / `Y_MAX`, 7 / 53: inclusive y window.
- `X_RST` / `Y_RST`, 40 / 30: reset position; must lie inside the window.
- `LFSR_W`, 16: LFSR width.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `MAX_TRIES`, 8: candidate budget per request; legal range 1..255.

- `clk_25M`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `apple_gen`  in  1  spawn request, sampled in IDLE only.
- `occ_ack`  in  1  occupancy answer valid.
- `occ_hit`  in  1  candidate cell is occupied by the snake; qualified by `occ_ack`.
- `occ_req`  out  1  occupancy query valid.
- `occ_x`  out  X_W  x coordinate of the queried cell.
- `occ_y`  out  Y_W  y coordinate of the queried cell.
- `apple_x_pos`  out  X_W  current apple x.
- `apple_y_pos`  out  Y_W  current apple y.
- `apple_busy`  out  1  a request is in progress.
- `apple_done`  out  1  one-cycle pulse: new position committed.
- `apple_fail`  out  1  qualifies `apple_done`: the committed position came from the fallback path.

## Operation
**Reset.** While `rst` is high:
- `apple_x_pos`/`apple_y_pos` = `X_RST`/`Y_RST`.
- LFSR = `SEED`; state = IDLE.
- `occ_req`, `apple_busy`, `apple_done` and `apple_fail` = 0; `occ_x`/`occ_y` = 0.

**LFSR.** Galois, maximal-length taps for `LFSR_W`, advancing every cycle in every state.

**Mapping.**
- SX = X_MAX-X_MIN+1 and WX = clog2(SX).
- x = X_MIN + f(lfsr[WX-1:0]), where f(v) = v>=SX ? v-SX : v.
- y uses span SY over the bits lfsr[WX+WY-1:WX], mapped the same way.
- Elaboration-time checks: 2^WX <= 2*SX, 2^WY <= 2*SY, WX+WY <= LFSR_W, X_MAX < 2^X_W, Y_MAX < 2^Y_W.
- Default window: a raw x value of 63 maps to 5, and 0 also maps to 5.

**FSM.**
- IDLE:
  - If `apple_gen`=1, go to DRAW and clear the try counter.
  - `apple_gen` in any other state is ignored, not queued.
- DRAW (one cycle):
  - Register the mapped candidate into `occ_x`/`occ_y`.
  - Increment the try counter.
  - Go to CHECK.
- CHECK:
  - Hold `occ_req`=1 with `occ_x`/`occ_y` stable until `occ_ack`=1.
  - `occ_ack` high with `occ_hit`=0: commit the candidate to the positions and go to IDLE.
  - `occ_hit`=1 with tries < MAX_TRIES: go to DRAW.
  - `occ_hit`=1 with tries = MAX_TRIES: commit the candidate anyway, raise the `apple_fail` qualifier, and go to IDLE.
- `apple_busy` = (state != IDLE).
- Positions change only on a commit; they hold across requests otherwise.
- A reset mid-request returns the block to IDLE with reset values immediately; no `apple_done` pulse is produced.

## Timing
- The request is sampled at edge E0.
- DRAW occupies the cycle after E0; `occ_req` rises after E1.
- If `occ_ack` arrives in the first CHECK cycle, the commit happens at E2; `apple_done` and the new positions are visible in the cycle after E2, so minimum latency is 3 cycles.
- Each extra ack-wait cycle adds 1 cycle; each retry adds 2 or more cycles.
- `apple_done`/`apple_fail` last exactly one cycle. A new request is accepted in the cycle `apple_done` is high, because the FSM is already in IDLE.
- `occ_req` drops in the cycle after the ack edge; `occ_ack` while `occ_req`=0 is ignored.
- All outputs are registered.

## Structure
- Shared package `snake_pkg`:
  - Playfield constants (X_W, Y_W, border limits).
  - FSM state enum: IDLE, DRAW, CHECK.
  - LFSR tap table per width.
- Sub-module `lfsr_gen` (parameters `W` and `SEED`; output is the current state). It is reused by future random-event blocks.
- The FSM, range mapping and try counter live in `apple_spawner`.

## Test plan
- Reset check: assert `rst` for 3 cycles -> positions = (40,30), all flags 0, `occ_req` = 0; release -> outputs unchanged while idle.
- Clean spawn: pulse `apple_gen`, ack with `occ_hit`=0 in the first CHECK cycle -> `apple_done` 3 cycles after the request, positions equal the registered `occ_x`/`occ_y`, values inside [5,67]x[7,53], `apple_fail` = 0.
- Retry: answer hit, hit, miss -> three DRAW cycles, the third candidate is committed, `apple_fail` = 0.
- Exhaustion: answer `occ_hit`=1 for all 8 queries -> the eighth candidate is committed with `apple_done`=1 and `apple_fail`=1.
- Handshake stall and ignored request: withhold `occ_ack` for 10 cycles -> `occ_req` and `occ_x`/`occ_y` stay stable; `apple_gen` pulses during that time are ignored (exactly one `apple_done` results).
- Reset mid-CHECK: assert `rst` while `occ_req` is high -> immediate return to IDLE, positions = (40,30), no `apple_done`; a scoreboard model of LFSR and mapping matches across 1000 requests.
